adc_serial_responder: RTL and testbench

Behavioural-synthesizable model of the dual-channel serial ADC that sits on the far end of the `ADC_*` pins. The block answers the converter driver: it latches two sample words on a conversion strobe, holds busy for a fixed conversion time, then shifts both results out MSB-first on `ADC_OUT[1:0]` while capturing the serial configuration word from `ADC_SD`. It is instantiated in the Pong bench in place of the physical ADC, and can be loaded on the FPGA as a loop-back test target.

---
 rtl/adc_serial_responder.sv | 148 ++++++++++++++
 tb/tb_adc_serial_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: dual-channel serial ADC model (convert, shift out, capture config); ADC_RESP_DITHER_EN adds LFSR dither on sample LSBs.
module adc_serial_responder #(
    parameter int DATA_W      = 12,
    parameter int CONV_CYCLES = 100,
    parameter int CFG_W       = 6
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              ADC_CNVST,
    input  logic              ADC_CS_N,
    input  logic              ADC_SCLK,
    input  logic              ADC_SD,
    input  logic              ADC_UB,
    input  logic              ADC_SEL,
    input  logic [DATA_W-1:0] sample0,
    input  logic [DATA_W-1:0] sample1,
    output logic [1:0]        ADC_OUT,
    output logic              busy,
    output logic [CFG_W-1:0]  cfg_word,
    output logic              cfg_valid,
    output logic              proto_err
);
    localparam int CW = $clog2(CONV_CYCLES);
    localparam int FW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(CFG_W + 1);
    typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;
    state_t            state_q, state_d;
    logic [2:0]        cnv_q, cnv_d, cs_q, cs_d, sclk_q, sclk_d;
    logic [1:0]        sd_q, sd_d;
    logic [CW-1:0]     conv_cnt_q, conv_cnt_d;
    logic [DATA_W-1:0] hold0_q, hold0_d, hold1_q, hold1_d, sh0_q, sh0_d, sh1_q, sh1_d;
    logic [DATA_W-1:0] fmt0, fmt1, dith;
    logic [FW-1:0]     falls_q, falls_d;
    logic [GW-1:0]     cfg_cnt_q, cfg_cnt_d;
    logic [CFG_W-1:0]  cfg_sr_q, cfg_sr_d, cfg_word_q, cfg_word_d;
    logic              cfg_hit_q, cfg_hit_d, cfg_valid_q, cfg_valid_d, proto_err_q, proto_err_d;
    logic [1:0]        out_q, out_d;
    logic              cnv_rise, cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic              start, load, in_shift, full;
`ifdef ADC_RESP_DITHER_EN
    logic [7:0]        lfsr_q, lfsr_d;
`endif
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnv_q       <= '0;
            cs_q        <= '1;
            sclk_q      <= '0;
            sd_q        <= '0;
            conv_cnt_q  <= '0;
            hold0_q     <= '0;
            hold1_q     <= '0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            falls_q     <= '0;
            cfg_cnt_q   <= '0;
            cfg_sr_q    <= '0;
            cfg_word_q  <= '0;
            cfg_hit_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            out_q       <= 2'b00;
`ifdef ADC_RESP_DITHER_EN
            lfsr_q      <= 8'hA5;
`endif
        end else begin
            state_q     <= state_d;
            cnv_q       <= cnv_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            sd_q        <= sd_d;
            conv_cnt_q  <= conv_cnt_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            falls_q     <= falls_d;
            cfg_cnt_q   <= cfg_cnt_d;
            cfg_sr_q    <= cfg_sr_d;
            cfg_word_q  <= cfg_word_d;
            cfg_hit_q   <= cfg_hit_d;
            cfg_valid_q <= cfg_valid_d;
            proto_err_q <= proto_err_d;
            out_q       <= out_d;
`ifdef ADC_RESP_DITHER_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cnv_rise ? CONVERT : IDLE;
            CONVERT: state_d = (conv_cnt_q == '0) ? READY : CONVERT;
            READY:   state_d = cnv_rise ? CONVERT : cs_fall ? SHIFT : READY;
            SHIFT:   state_d = cs_rise ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cnv_d     = {cnv_q[1:0], ADC_CNVST};
        cs_d      = {cs_q[1:0], ADC_CS_N};
        sclk_d    = {sclk_q[1:0], ADC_SCLK};
        sd_d      = {sd_q[0], ADC_SD};
        cnv_rise  = cnv_q[1] & ~cnv_q[2];
        cs_fall   = ~cs_q[1] & cs_q[2];
        cs_rise   = cs_q[1] & ~cs_q[2];
        sclk_rise = sclk_q[1] & ~sclk_q[2];
        sclk_fall = ~sclk_q[1] & sclk_q[2];
        start     = cnv_rise & (state_q == IDLE || state_q == READY);
        load      = cs_fall & ~cnv_rise & (state_q == READY);
        in_shift  = (state_q == SHIFT) & ~cs_rise;
        full      = falls_q == FW'(DATA_W);
`ifdef ADC_RESP_DITHER_EN
        dith      = {{(DATA_W-2){1'b0}}, lfsr_q[1:0]};
        lfsr_d    = start ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
`else
        dith      = '0;
`endif
        hold0_d    = start ? sample0 ^ dith : hold0_q;
        hold1_d    = start ? sample1 ^ dith : hold1_q;
        conv_cnt_d = start ? CW'(CONV_CYCLES - 1) :
                     (state_q == CONVERT && conv_cnt_q != '0) ? conv_cnt_q - CW'(1) : conv_cnt_q;
        // bipolar output is offset binary with the MSB flipped into two's complement
        fmt0       = hold0_q ^ {~ADC_UB, {(DATA_W-1){1'b0}}};
        fmt1       = hold1_q ^ {~ADC_UB, {(DATA_W-1){1'b0}}};
        sh0_d      = load ? (ADC_SEL ? fmt1 : fmt0) :
                     (in_shift & sclk_fall) ? {sh0_q[DATA_W-2:0], 1'b0} : sh0_q;
        sh1_d      = load ? (ADC_SEL ? fmt0 : fmt1) :
                     (in_shift & sclk_fall) ? {sh1_q[DATA_W-2:0], 1'b0} : sh1_q;
        falls_d    = load ? '0 : (in_shift & sclk_fall & ~full) ? falls_q + FW'(1) : falls_q;
        cfg_sr_d   = (in_shift & sclk_rise) ? {cfg_sr_q[CFG_W-2:0], sd_q[1]} : cfg_sr_q;
        cfg_cnt_d  = load ? '0 :
                     (in_shift & sclk_rise & cfg_cnt_q != GW'(CFG_W)) ? cfg_cnt_q + GW'(1) : cfg_cnt_q;
        cfg_hit_d  = in_shift & sclk_rise & (cfg_cnt_q == GW'(CFG_W - 1));
        cfg_valid_d = cfg_hit_q;
        cfg_word_d  = cfg_hit_q ? cfg_sr_q : cfg_word_q;
        proto_err_d = proto_err_q | (cnv_rise & state_q == CONVERT) | (cs_rise & state_q == SHIFT & ~full);
        out_d       = in_shift ? {sh1_q[DATA_W-1], sh0_q[DATA_W-1]} : 2'b00;
    end
    always_comb begin
        busy      = state_q == CONVERT;
        ADC_OUT   = out_q;
        cfg_word  = cfg_word_q;
        cfg_valid = cfg_valid_q;
        proto_err = proto_err_q;
    end
endmodule

// File: tb/tb_adc_serial_responder.sv
// tb_adc_serial_responder: directed checks of conversion timing, lane formatting, config capture and protocol errors.
module tb_adc_serial_responder;
    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ADC_CNVST = 1'b0, ADC_CS_N = 1'b1, ADC_SCLK = 1'b0, ADC_SD = 1'b0, ADC_UB = 1'b1, ADC_SEL = 1'b0;
    logic [11:0] sample0 = '0, sample1 = '0;
    logic [1:0]  ADC_OUT;
    logic        busy, cfg_valid, proto_err;
    logic [5:0]  cfg_word;
    int          tests = 0, fails = 0, pulses = 0;

    adc_serial_responder dut (
        .Clock(Clock), .Reset_n(Reset_n), .ADC_CNVST(ADC_CNVST), .ADC_CS_N(ADC_CS_N),
        .ADC_SCLK(ADC_SCLK), .ADC_SD(ADC_SD), .ADC_UB(ADC_UB), .ADC_SEL(ADC_SEL),
        .sample0(sample0), .sample1(sample1), .ADC_OUT(ADC_OUT), .busy(busy),
        .cfg_word(cfg_word), .cfg_valid(cfg_valid), .proto_err(proto_err)
    );

    always #5 Clock = ~Clock;
    always @(negedge Clock) if (cfg_valid) pulses++;

    task automatic convert(input logic [11:0] s0, input logic [11:0] s1, output int lat, output int width);
        sample0 = s0; sample1 = s1; ADC_CNVST = 1'b1; lat = 0; width = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge Clock);
            if (i == 5) ADC_CNVST = 1'b0;
            if (busy) begin
                if (lat == 0) lat = i;
                width++;
            end else if (lat != 0) break;
        end
    endtask

    task automatic read_frame(input logic ub, input logic sel, input logic [11:0] sd_bits, input int nbits,
                              output logic [11:0] l0, output logic [11:0] l1);
        ADC_UB = ub; ADC_SEL = sel; ADC_CS_N = 1'b0; l0 = '0; l1 = '0;
        repeat (6) @(negedge Clock);
        for (int i = 0; i < nbits; i++) begin
            l0 = {l0[10:0], ADC_OUT[0]}; l1 = {l1[10:0], ADC_OUT[1]};
            ADC_SD = sd_bits[11-i];
            @(negedge Clock); ADC_SCLK = 1'b1;
            repeat (3) @(negedge Clock); ADC_SCLK = 1'b0;
            repeat (5) @(negedge Clock);
        end
        ADC_CS_N = 1'b1;
        repeat (6) @(negedge Clock);
    endtask

    task automatic test_reset;
        #1;
        tests++; if (ADC_OUT !== 2'b00) begin fails++; $display("FAIL reset_out got %b want 00", ADC_OUT); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (cfg_word !== 6'd0) begin fails++; $display("FAIL reset_cfg_word got %h want 00", cfg_word); end
        tests++; if (cfg_valid !== 1'b0) begin fails++; $display("FAIL reset_cfg_valid got %b want 0", cfg_valid); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clock);
    endtask

    task automatic test_unipolar;
        int lat, width; logic [11:0] l0, l1;
        convert(12'hABC, 12'h123, lat, width);
        tests++; if (lat != 3) begin fails++; $display("FAIL busy_latency got %0d want 3", lat); end
        tests++; if (width != 100) begin fails++; $display("FAIL busy_width got %0d want 100", width); end
        read_frame(1'b1, 1'b0, 12'h000, 12, l0, l1);
        tests++; if (l0 !== 12'hABC) begin fails++; $display("FAIL uni_lane0 got %h want abc", l0); end
        tests++; if (l1 !== 12'h123) begin fails++; $display("FAIL uni_lane1 got %h want 123", l1); end
        tests++; if (ADC_OUT !== 2'b00) begin fails++; $display("FAIL uni_idle_out got %b want 00", ADC_OUT); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL uni_proto got %b want 0", proto_err); end
    endtask

    task automatic test_bipolar;
        int lat, width; logic [11:0] l0, l1;
        convert(12'hABC, 12'h123, lat, width);
        read_frame(1'b0, 1'b0, 12'h000, 12, l0, l1);
        tests++; if (l0 !== 12'h2BC) begin fails++; $display("FAIL bip_lane0 got %h want 2bc", l0); end
        tests++; if (l1 !== 12'h923) begin fails++; $display("FAIL bip_lane1 got %h want 923", l1); end
    endtask

    task automatic test_swap;
        int lat, width; logic [11:0] l0, l1;
        convert(12'hFFF, 12'h000, lat, width);
        read_frame(1'b1, 1'b1, 12'h000, 12, l0, l1);
        tests++; if (l0 !== 12'h000) begin fails++; $display("FAIL swap_lane0 got %h want 000", l0); end
        tests++; if (l1 !== 12'hFFF) begin fails++; $display("FAIL swap_lane1 got %h want fff", l1); end
    endtask

    task automatic test_config;
        int lat, width, p0; logic [11:0] l0, l1;
        convert(12'h555, 12'hAAA, lat, width);
        p0 = pulses;
        read_frame(1'b1, 1'b0, 12'b101101_000000, 12, l0, l1);
        tests++; if (cfg_word !== 6'b101101) begin fails++; $display("FAIL cfg_word1 got %b want 101101", cfg_word); end
        tests++; if (pulses - p0 != 1) begin fails++; $display("FAIL cfg_pulses1 got %0d want 1", pulses - p0); end
        tests++; if (l0 !== 12'h555) begin fails++; $display("FAIL cfg_lane0 got %h want 555", l0); end
        convert(12'h555, 12'hAAA, lat, width);
        p0 = pulses;
        read_frame(1'b1, 1'b0, 12'b010011_111111, 12, l0, l1);
        tests++; if (cfg_word !== 6'b010011) begin fails++; $display("FAIL cfg_word2 got %b want 010011", cfg_word); end
        tests++; if (pulses - p0 != 1) begin fails++; $display("FAIL cfg_pulses2 got %0d want 1", pulses - p0); end
    endtask

    task automatic test_back_to_back;
        int lat, width; logic [11:0] l0, l1;
        convert(12'h111, 12'h222, lat, width);
        convert(12'h456, 12'h789, lat, width);
        tests++; if (width != 100) begin fails++; $display("FAIL b2b_width got %0d want 100", width); end
        read_frame(1'b1, 1'b0, 12'h000, 12, l0, l1);
        tests++; if (l0 !== 12'h456) begin fails++; $display("FAIL b2b_lane0 got %h want 456", l0); end
        tests++; if (l1 !== 12'h789) begin fails++; $display("FAIL b2b_lane1 got %h want 789", l1); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL b2b_proto got %b want 0", proto_err); end
    endtask

    task automatic test_proto;
        int lat, width; logic [11:0] l0, l1;
        sample0 = 12'h321; ADC_CNVST = 1'b1;
        repeat (5) @(negedge Clock); ADC_CNVST = 1'b0;
        repeat (20) @(negedge Clock); ADC_CNVST = 1'b1;
        repeat (5) @(negedge Clock); ADC_CNVST = 1'b0;
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_cnvst got %b want 1", proto_err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL proto_busy got %b want 1", busy); end
        Reset_n = 1'b0; #1;
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL proto_clear got %b want 0", proto_err); end
        @(negedge Clock); Reset_n = 1'b1; repeat (3) @(negedge Clock);
        convert(12'h800, 12'h800, lat, width);
        read_frame(1'b1, 1'b0, 12'h000, 5, l0, l1);
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_short got %b want 1", proto_err); end
        tests++; if (ADC_OUT !== 2'b00) begin fails++; $display("FAIL proto_out got %b want 00", ADC_OUT); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL proto_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_shift;
        int lat, width; logic [11:0] l0, l1; logic [11:0] sd;
        Reset_n = 1'b0; @(negedge Clock); Reset_n = 1'b1; repeat (3) @(negedge Clock);
        convert(12'hFFF, 12'hFFF, lat, width);
        sd = 12'b111000_000000;
        ADC_UB = 1'b1; ADC_SEL = 1'b0; ADC_CS_N = 1'b0;
        repeat (6) @(negedge Clock);
        for (int i = 0; i < 6; i++) begin
            ADC_SD = sd[11-i];
            @(negedge Clock); ADC_SCLK = 1'b1;
            repeat (3) @(negedge Clock); ADC_SCLK = 1'b0;
            repeat (5) @(negedge Clock);
        end
        tests++; if (ADC_OUT !== 2'b11) begin fails++; $display("FAIL mid_out_pre got %b want 11", ADC_OUT); end
        tests++; if (cfg_word !== 6'b111000) begin fails++; $display("FAIL mid_cfg_pre got %b want 111000", cfg_word); end
        Reset_n = 1'b0; #1;
        tests++; if (ADC_OUT !== 2'b00) begin fails++; $display("FAIL mid_out_rst got %b want 00", ADC_OUT); end
        tests++; if (cfg_word !== 6'd0) begin fails++; $display("FAIL mid_cfg_rst got %b want 000000", cfg_word); end
        tests++; if (busy !== 1'b0 || cfg_valid !== 1'b0 || proto_err !== 1'b0) begin
            fails++; $display("FAIL mid_flags_rst got %b%b%b want 000", busy, cfg_valid, proto_err);
        end
        ADC_CS_N = 1'b1;
        @(negedge Clock); Reset_n = 1'b1; repeat (3) @(negedge Clock);
        convert(12'h5A5, 12'hA5A, lat, width);
        tests++; if (width != 100) begin fails++; $display("FAIL mid_width got %0d want 100", width); end
        read_frame(1'b1, 1'b0, 12'h000, 12, l0, l1);
        tests++; if (l0 !== 12'h5A5) begin fails++; $display("FAIL mid_lane0 got %h want 5a5", l0); end
        tests++; if (l1 !== 12'hA5A) begin fails++; $display("FAIL mid_lane1 got %h want a5a", l1); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL mid_proto got %b want 0", proto_err); end
    endtask

    initial begin
        @(negedge Clock);
        test_reset;
        test_unipolar;
        test_bipolar;
        test_swap;
        test_config;
        test_back_to_back;
        test_proto;
        test_reset_mid_shift;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
